// File: rtl/kitchen_safety_pkg.sv
// Shared definitions for the multi-zone kitchen safety controller: zone state encodings
// and counter width helpers.
package kitchen_safety_pkg;

  localparam logic [1:0] ZoneIdle     = 2'd0;
  localparam logic [1:0] ZoneVent     = 2'd1;
  localparam logic [1:0] ZoneSprinkle = 2'd2;
  localparam logic [1:0] ZonePurge    = 2'd3;

  // Width of a debounce counter able to count up to the debounce threshold.
  function automatic int unsigned db_cnt_width(int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Width of the shared run/hold counter, never narrower than one bit.
  function automatic int unsigned zone_cnt_width(int unsigned run_cycles,
                                                 int unsigned hold_cycles);
    int unsigned m;
    m = (run_cycles > hold_cycles) ? run_cycles : hold_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/kitchen_zone_ctrl.sv
// One kitchen zone: debounces stove/fire/smoke, then runs the IDLE/VENT/SPRINKLE/PURGE
// machine that drives the zone's sprinkler and ventilation.
module kitchen_zone_ctrl
  import kitchen_safety_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = 4,
  parameter int unsigned SPRINKLER_MIN_CYCLES = 8,
  parameter int unsigned VENT_HOLD_CYCLES     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stove_on,
  input  logic fire_det,
  input  logic smoke_det,
  output logic sprinkler,
  output logic vent,
  output logic spr_enter
);

  localparam int unsigned DbW  = db_cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned CntW = zone_cnt_width(SPRINKLER_MIN_CYCLES, VENT_HOLD_CYCLES);

  localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] RunLoad  = CntW'(SPRINKLER_MIN_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(VENT_HOLD_CYCLES - 1);

  // Bit order of the debounced inputs: 0 = stove, 1 = fire, 2 = smoke.
  logic [2:0]          raw;
  logic [2:0]          filt_q, filt_d;
  logic [2:0][DbW-1:0] db_cnt_q, db_cnt_d;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            spr_cond, smk_cond;

  assign raw = {smoke_det, fire_det, stove_on};

  // The edge on which the counter would reach the threshold is the edge that flips filtered.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (raw[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          filt_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Smoke with the stove off is unattended and treated like fire.
  assign spr_cond = filt_q[1] | (filt_q[2] & ~filt_q[0]);
  assign smk_cond = filt_q[2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZoneIdle: begin
        if (spr_cond) begin
          state_d = ZoneSprinkle;
          cnt_d   = RunLoad;
        end else if (smk_cond) begin
          state_d = ZoneVent;
        end
      end
      ZoneVent: begin
        if (spr_cond) begin
          state_d = ZoneSprinkle;
          cnt_d   = RunLoad;
        end else if (!smk_cond) begin
          state_d = ZonePurge;
          cnt_d   = HoldLoad;
        end
      end
      ZoneSprinkle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end
        if (!spr_cond && (cnt_q == '0)) begin
          state_d = ZonePurge;
          cnt_d   = HoldLoad;
        end
      end
      ZonePurge: begin
        if (spr_cond) begin
          state_d = ZoneSprinkle;
          cnt_d   = RunLoad;
        end else if (smk_cond) begin
          state_d = ZoneVent;
        end else if (cnt_q == '0) begin
          state_d = ZoneIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = ZoneIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= '0;
      db_cnt_q <= '0;
      state_q  <= ZoneIdle;
      cnt_q    <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // Pulses on the cycle before the state register enters SPRINKLE, so the alarm flop
  // and the sprinkler rise on the same edge.
  assign spr_enter = (state_d == ZoneSprinkle) && (state_q != ZoneSprinkle);

  assign sprinkler = (state_q == ZoneSprinkle);
  assign vent      = (state_q != ZoneIdle);

endmodule

// File: rtl/kitchen_safety_ctrl.sv
// Multi-zone kitchen safety controller: per-zone sprinkler/vent control plus a latched
// global alarm with acknowledge.
module kitchen_safety_ctrl
  import kitchen_safety_pkg::*;
#(
  parameter int unsigned NUM_ZONES            = 2,
  parameter int unsigned DEBOUNCE_CYCLES      = 4,
  parameter int unsigned SPRINKLER_MIN_CYCLES = 8,
  parameter int unsigned VENT_HOLD_CYCLES     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_ZONES-1:0] stove_on,
  input  logic [NUM_ZONES-1:0] fire_det,
  input  logic [NUM_ZONES-1:0] smoke_det,
  input  logic                 alarm_ack,
  output logic [NUM_ZONES-1:0] sprinkler,
  output logic [NUM_ZONES-1:0] vent,
  output logic                 alarm,
  output logic [NUM_ZONES-1:0] alarm_zone
);

  logic [NUM_ZONES-1:0] spr_enter;
  logic [NUM_ZONES-1:0] alarm_zone_q, alarm_zone_d;
  logic                 alarm_q, alarm_d;
  logic                 alarm_clr;

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    kitchen_zone_ctrl #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .SPRINKLER_MIN_CYCLES (SPRINKLER_MIN_CYCLES),
      .VENT_HOLD_CYCLES     (VENT_HOLD_CYCLES)
    ) u_zone (
      .clk       (clk),
      .rst_n     (rst_n),
      .stove_on  (stove_on[z]),
      .fire_det  (fire_det[z]),
      .smoke_det (smoke_det[z]),
      .sprinkler (sprinkler[z]),
      .vent      (vent[z]),
      .spr_enter (spr_enter[z])
    );
  end

  // A new entry into SPRINKLE wins over an acknowledge on the same edge.
  always_comb begin
    alarm_clr    = alarm_ack & ~(|sprinkler);
    alarm_zone_d = (alarm_clr ? '0 : alarm_zone_q) | spr_enter;
    alarm_d      = (alarm_q & ~alarm_clr) | (|spr_enter);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q      <= 1'b0;
      alarm_zone_q <= '0;
    end else begin
      alarm_q      <= alarm_d;
      alarm_zone_q <= alarm_zone_d;
    end
  end

  assign alarm      = alarm_q;
  assign alarm_zone = alarm_zone_q;

endmodule

// File: tb/tb_kitchen_safety_ctrl.sv
// Directed bench for kitchen_safety_ctrl with default parameters; edge counts in each task
// are relative to the moment the scenario's stimulus is applied.
module tb_kitchen_safety_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] stove_on, fire_det, smoke_det;
  logic       alarm_ack;
  logic [1:0] sprinkler, vent, alarm_zone;
  logic       alarm;

  int n_checks = 0;
  int n_fail   = 0;

  kitchen_safety_ctrl #(
    .NUM_ZONES            (2),
    .DEBOUNCE_CYCLES      (4),
    .SPRINKLER_MIN_CYCLES (8),
    .VENT_HOLD_CYCLES     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stove_on   (stove_on),
    .fire_det   (fire_det),
    .smoke_det  (smoke_det),
    .alarm_ack  (alarm_ack),
    .sprinkler  (sprinkler),
    .vent       (vent),
    .alarm      (alarm),
    .alarm_zone (alarm_zone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stove_on  = '0;
    fire_det  = '0;
    smoke_det = '0;
    alarm_ack = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stove_on  = '0;
    fire_det  = '0;
    smoke_det = '0;
    alarm_ack = 1'b0;
    rst_n     = 1'b0;
    #2;
    n_checks++; if (sprinkler !== 2'b00) begin n_fail++;
      $display("FAIL reset_spr: got %b want 00", sprinkler); end
    n_checks++; if (vent !== 2'b00) begin n_fail++;
      $display("FAIL reset_vent: got %b want 00", vent); end
    n_checks++; if (alarm !== 1'b0) begin n_fail++;
      $display("FAIL reset_alarm: got %b want 0", alarm); end
    n_checks++; if (alarm_zone !== 2'b00) begin n_fail++;
      $display("FAIL reset_zone: got %b want 00", alarm_zone); end
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_checks++; if ({sprinkler, vent, alarm, alarm_zone} !== 7'b0) begin n_fail++;
        $display("FAIL idle_outputs e%0d: got %b want 0", e,
                 {sprinkler, vent, alarm, alarm_zone}); end
    end
  endtask

  task automatic test_cooking_smoke();
    logic [1:0] exp_v;
    do_reset();
    stove_on  = 2'b01;
    smoke_det = 2'b01;
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e == 10) smoke_det = 2'b00;
      exp_v = ((e >= 5) && (e <= 30)) ? 2'b01 : 2'b00;
      n_checks++; if (vent !== exp_v) begin n_fail++;
        $display("FAIL smoke_vent e%0d: got %b want %b", e, vent, exp_v); end
      n_checks++; if (sprinkler !== 2'b00) begin n_fail++;
        $display("FAIL smoke_spr e%0d: got %b want 00", e, sprinkler); end
      n_checks++; if (alarm !== 1'b0) begin n_fail++;
        $display("FAIL smoke_alarm e%0d: got %b want 0", e, alarm); end
    end
    stove_on = 2'b00;
  endtask

  task automatic test_fire_pulse();
    logic [1:0] exp_s, exp_v;
    logic       exp_a;
    do_reset();
    fire_det = 2'b10;
    for (int e = 1; e <= 29; e++) begin
      step();
      if (e == 4) fire_det = 2'b00;
      exp_s = ((e >= 5) && (e <= 12)) ? 2'b10 : 2'b00;
      exp_v = ((e >= 5) && (e <= 28)) ? 2'b10 : 2'b00;
      exp_a = (e >= 5);
      n_checks++; if (sprinkler !== exp_s) begin n_fail++;
        $display("FAIL fire_spr e%0d: got %b want %b", e, sprinkler, exp_s); end
      n_checks++; if (vent !== exp_v) begin n_fail++;
        $display("FAIL fire_vent e%0d: got %b want %b", e, vent, exp_v); end
      n_checks++; if (alarm !== exp_a) begin n_fail++;
        $display("FAIL fire_alarm e%0d: got %b want %b", e, alarm, exp_a); end
    end
    n_checks++; if (alarm_zone !== 2'b10) begin n_fail++;
      $display("FAIL fire_zone: got %b want 10", alarm_zone); end
  endtask

  task automatic test_glitch();
    do_reset();
    fire_det = 2'b01;
    for (int e = 1; e <= 13; e++) begin
      step();
      if (e == 3) fire_det = 2'b00;
      n_checks++; if ({sprinkler, vent, alarm, alarm_zone} !== 7'b0) begin n_fail++;
        $display("FAIL glitch_outputs e%0d: got %b want 0", e,
                 {sprinkler, vent, alarm, alarm_zone}); end
    end
  endtask

  task automatic test_ack();
    do_reset();
    fire_det = 2'b10;
    for (int e = 1; e <= 4; e++) step();
    fire_det = 2'b00;
    step();  // edge 5: zone 1 enters SPRINKLE
    n_checks++; if ((sprinkler !== 2'b10) || (alarm !== 1'b1)) begin n_fail++;
      $display("FAIL ack_enter: got spr=%b alarm=%b want spr=10 alarm=1", sprinkler, alarm); end
    alarm_ack = 1'b1;
    for (int e = 6; e <= 12; e++) begin
      step();
      n_checks++; if ((alarm !== 1'b1) || (alarm_zone !== 2'b10)) begin n_fail++;
        $display("FAIL ack_ignored e%0d: got alarm=%b zone=%b want 1/10", e, alarm,
                 alarm_zone); end
    end
    alarm_ack = 1'b0;
    step();  // edge 13: zone 1 to PURGE
    n_checks++; if ((sprinkler !== 2'b00) || (alarm !== 1'b1)) begin n_fail++;
      $display("FAIL ack_hold: got spr=%b alarm=%b want spr=00 alarm=1", sprinkler, alarm); end
    fire_det = 2'b01;
    for (int e = 14; e <= 17; e++) step();
    alarm_ack = 1'b1;
    step();  // edge 18: zone 0 enters SPRINKLE together with ack
    n_checks++; if ((alarm !== 1'b1) || (alarm_zone !== 2'b01) || (sprinkler !== 2'b01))
      begin n_fail++;
      $display("FAIL ack_set_wins: got alarm=%b zone=%b spr=%b want 1/01/01", alarm,
               alarm_zone, sprinkler); end
    fire_det = 2'b00;
    for (int e = 19; e <= 26; e++) begin
      step();
      n_checks++; if ((alarm !== 1'b1) || (alarm_zone !== 2'b01)) begin n_fail++;
        $display("FAIL ack_sprinkling e%0d: got alarm=%b zone=%b want 1/01", e, alarm,
                 alarm_zone); end
    end
    n_checks++; if (sprinkler !== 2'b00) begin n_fail++;
      $display("FAIL ack_spr_drop: got %b want 00", sprinkler); end
    step();  // edge 27: ack now takes effect
    n_checks++; if ((alarm !== 1'b0) || (alarm_zone !== 2'b00)) begin n_fail++;
      $display("FAIL ack_clear: got alarm=%b zone=%b want 0/00", alarm, alarm_zone); end
    alarm_ack = 1'b0;
  endtask

  task automatic test_unattended();
    logic [1:0] exp_s;
    do_reset();
    smoke_det = 2'b01;
    for (int e = 1; e <= 5; e++) step();
    n_checks++; if ((sprinkler !== 2'b01) || (alarm !== 1'b1) || (alarm_zone !== 2'b01))
      begin n_fail++;
      $display("FAIL unatt_enter: got spr=%b alarm=%b zone=%b want 01/1/01", sprinkler,
               alarm, alarm_zone); end
    stove_on = 2'b01;
    for (int e = 6; e <= 32; e++) begin
      step();
      exp_s = (e <= 12) ? 2'b01 : 2'b00;
      n_checks++; if (sprinkler !== exp_s) begin n_fail++;
        $display("FAIL unatt_spr e%0d: got %b want %b", e, sprinkler, exp_s); end
      n_checks++; if (vent !== 2'b01) begin n_fail++;
        $display("FAIL unatt_vent e%0d: got %b want 01", e, vent); end
    end
    smoke_det = 2'b00;
    stove_on  = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_s;
    do_reset();
    fire_det = 2'b01;
    for (int e = 1; e <= 7; e++) step();
    n_checks++; if ((sprinkler !== 2'b01) || (alarm !== 1'b1)) begin n_fail++;
      $display("FAIL rmid_pre: got spr=%b alarm=%b want 01/1", sprinkler, alarm); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({sprinkler, vent, alarm, alarm_zone} !== 7'b0) begin n_fail++;
      $display("FAIL rmid_async: got %b want 0", {sprinkler, vent, alarm, alarm_zone}); end
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      exp_s = (e == 5) ? 2'b01 : 2'b00;
      n_checks++; if (sprinkler !== exp_s) begin n_fail++;
        $display("FAIL rmid_spr e%0d: got %b want %b", e, sprinkler, exp_s); end
      n_checks++; if (alarm !== (e == 5)) begin n_fail++;
        $display("FAIL rmid_alarm e%0d: got %b want %b", e, alarm, (e == 5)); end
    end
    fire_det = 2'b00;
  endtask

  initial begin
    rst_n     = 1'b0;
    stove_on  = '0;
    fire_det  = '0;
    smoke_det = '0;
    alarm_ack = 1'b0;
    test_reset();
    test_cooking_smoke();
    test_fire_pulse();
    test_glitch();
    test_ack();
    test_unattended();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kitchen_safety_ctrl.md
# kitchen_safety_ctrl

Multi-zone, debounced, sequential successor to the combinational kitchen fire/smoke detector. Each of `NUM_ZONES` zones filters its stove, fire and smoke inputs and runs a small state machine. The state machine drives that zone's sprinkler and ventilation with a minimum sprinkler run time and a post-hazard ventilation purge. A global latched alarm with an acknowledge sits above all zones and feeds the home-automation top level.

## Interface
Parameters:
- `NUM_ZONES`, 2: number of independent kitchen zones, ≥1.
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a raw input must differ from its filtered value before the filtered value changes, ≥1.
- `SPRINKLER_MIN_CYCLES`, 8: minimum cycles the sprinkler stays on once triggered, ≥1.
- `VENT_HOLD_CYCLES`, 16: purge cycles of ventilation after a hazard clears, ≥1.

Ports:
- `clk`, in, 1: single clock for the block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `stove_on`, in, `NUM_ZONES`: bit z is 1 when the stove in zone z is on.
- `fire_det`, in, `NUM_ZONES`: fire detector, per zone.
- `smoke_det`, in, `NUM_ZONES`: smoke detector, per zone.
- `alarm_ack`, in, 1: level acknowledge for the global alarm.
- `sprinkler`, out, `NUM_ZONES`: sprinkler enable, per zone.
- `vent`, out, `NUM_ZONES`: ventilation enable, per zone.
- `alarm`, out, 1: latched global fire alarm.
- `alarm_zone`, out, `NUM_ZONES`: sticky mask of zones that entered SPRINKLE since the last acknowledge.

## Operation
- **Debounce (per input bit):**
  - The counter increments while raw ≠ filtered and clears when raw = filtered.
  - When the counter reaches `DEBOUNCE_CYCLES`, filtered takes the raw value and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- **Conditions:** F, S and T are the filtered fire, smoke and stove bits.
  - `spr_cond = F | (S & ~T)`. Smoke with the stove off is treated as a hazard; smoke with the stove on is cooking smoke.
  - `smk_cond = S`.
- **Zone FSM** (states IDLE, VENT, SPRINKLE, PURGE):
  - **IDLE:**
    - `spr_cond` → SPRINKLE; load the run counter with `SPRINKLER_MIN_CYCLES-1`.
    - Else `smk_cond` → VENT.
  - **VENT:**
    - `spr_cond` → SPRINKLE; load the run counter.
    - Else `~smk_cond` → PURGE; load the hold counter with `VENT_HOLD_CYCLES-1`.
  - **SPRINKLE:**
    - The run counter decrements to 0 and saturates there.
    - Exit to PURGE (load the hold counter) only when `~spr_cond` and the run counter is 0.
    - While `spr_cond` holds, stay in SPRINKLE.
  - **PURGE:**
    - Priority order: `spr_cond` → SPRINKLE (load the run counter); else `smk_cond` → VENT; else hold counter = 0 → IDLE; else decrement.
- **Outputs:** Moore-decoded from the state register only, with no combinational path from any input.
  - `sprinkler[z] = (state==SPRINKLE)`.
  - `vent[z] = (state!=IDLE)`.
- **Alarm:**
  - On any cycle where zone z transitions into SPRINKLE, set `alarm` and `alarm_zone[z]`.
  - Clear both when `alarm_ack=1` and no zone is in SPRINKLE.
  - Set has priority over clear in the same cycle.
  - `alarm_ack` while any zone is in SPRINKLE is ignored.
- **Shared counters:** run and hold share one per-zone counter of width `$clog2(max(SPRINKLER_MIN_CYCLES,VENT_HOLD_CYCLES))`, minimum 1.

## Timing
- **Reset values:** every output is 0.
  - All states are IDLE, all filtered bits are 0, all counters are 0.
  - Assertion of `rst_n` clears everything immediately, mid-operation included; the sprinkler drops without waiting for the minimum run time.
- **Latency:** a raw change held stable for `DEBOUNCE_CYCLES` rising edges updates filtered on the last of those edges. The state and outputs change on the following edge, for a total of `DEBOUNCE_CYCLES+1` edges.
- **Glitches:** pulses shorter than `DEBOUNCE_CYCLES` cycles have no effect.
- **Sprinkler duration:**
  - A trigger that clears immediately still gives exactly `SPRINKLER_MIN_CYCLES` cycles of `sprinkler=1`.
  - Otherwise `sprinkler` stays on until `spr_cond` has been false for one cycle after the minimum elapses.
- **Purge duration:** PURGE lasts exactly `VENT_HOLD_CYCLES` cycles when uninterrupted, with `vent=1` and `sprinkler=0`.
- **Alarm timing:** `alarm` rises in the same cycle that `sprinkler[z]` rises.
- **After reset release:** a fire already present needs `DEBOUNCE_CYCLES+1` edges before it acts.

## Structure
- **Shared package `kitchen_safety_pkg`:** zone state encodings (IDLE=2'd0, VENT=2'd1, SPRINKLE=2'd2, PURGE=2'd3) and a `clog2`-based width helper.
- **Sub-module `kitchen_zone_ctrl`:**
  - Contains three debouncers, the zone FSM and the counter.
  - Outputs `sprinkler`, `vent` and a one-cycle `spr_enter` pulse.
  - Instantiated `NUM_ZONES` times via `generate`.
  - The top level holds only the alarm and `alarm_zone` logic.

## Test plan
All scenarios use the default parameters.
- **Cooking smoke:** zone 0 `stove_on=1`, `smoke_det=1` for 10 cycles, then 0.
  - `vent[0]` rises 5 edges after smoke asserts; `sprinkler[0]` stays 0.
  - After smoke clears and debounces, `vent[0]` stays 1 for 16 more cycles, then falls.
  - `alarm` stays 0.
- **Fire pulse:** zone 1 `fire_det` high for 4 cycles.
  - `sprinkler[1]` is 1 for exactly 8 cycles, then PURGE gives 16 cycles of `vent` only.
  - `alarm=1` and `alarm_zone=2'b10`.
- **Glitch rejection:** `fire_det[0]` high for 3 cycles → all outputs stay 0.
- **Acknowledge:**
  - `alarm_ack` held during SPRINKLE → `alarm` stays 1.
  - `alarm_ack` after the sprinkler drops → `alarm` and `alarm_zone` go to 0 next edge.
  - A new zone 0 trigger on the same edge as an ack → `alarm=1`, `alarm_zone=2'b01`.
- **Unattended smoke:** `stove_on=0`, `smoke_det=1` → SPRINKLE and alarm; raising `stove_on` afterwards has no effect until the minimum run time elapses.
- **Reset mid-sprinkle:** `rst_n` pulled low mid-sprinkle → `sprinkler`, `vent` and `alarm` go to 0 asynchronously. With fire still present at release, `sprinkler` re-asserts after 5 edges.
